register_scoreboard: RTL and testbench

- Tracks pending register writes between decode issue and writeback.
- Drives the register_read_1_contended and register_read_2_contended inputs of the decode stage.
- Lets decode stall on RAW hazards and on register-write overflow.
- Sits beside the register file: issue comes from decode's transfer to the next stage, clears come from the writeback stage.

---
 rtl/register_scoreboard.sv | 92 +++++++++
 tb/tb_register_scoreboard.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/register_scoreboard.sv
// Per-register outstanding-write counters between decode issue and writeback.
// Flags RAW contention for the two decode read ports and blocks issue on a saturated counter.
module register_scoreboard #(
    parameter int NUM_REGISTERS           = 32,
    parameter int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS),
    parameter int PENDING_WIDTH           = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] query_1,
    output logic                               query_1_contended,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] query_2,
    output logic                               query_2_contended,
    input  logic                               issue_valid,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] issue_register,
    input  logic                               issue_register_valid,
    output logic                               issue_ready,
    input  logic                               writeback_valid,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] writeback_register,
    input  logic                               flush,
    output logic                               any_pending,
    output logic                               underflow_error
);

    localparam logic [PENDING_WIDTH-1:0] PENDING_MAX = {PENDING_WIDTH{1'b1}};
    localparam logic [PENDING_WIDTH-1:0] PENDING_ONE = PENDING_WIDTH'(1);

    logic [PENDING_WIDTH-1:0] pending_q [NUM_REGISTERS];
    logic [PENDING_WIDTH-1:0] pending_d [NUM_REGISTERS];
    logic                     underflow_error_q;
    logic                     underflow_error_d;

    logic inc;
    logic dec;

    // Readiness looks only at registered state; a same-cycle writeback is not credited.
    assign issue_ready = !issue_register_valid
                      || (issue_register == '0)
                      || (pending_q[issue_register] != PENDING_MAX);

    assign inc = issue_valid && issue_register_valid && (issue_register != '0) && issue_ready;
    assign dec = writeback_valid && (writeback_register != '0);

    always_comb begin
        logic inc_hit;
        logic dec_hit;
        underflow_error_d = underflow_error_q;
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            pending_d[i] = pending_q[i];
            inc_hit      = inc && (issue_register == REGISTER_INDEXING_WIDTH'(i));
            dec_hit      = dec && (writeback_register == REGISTER_INDEXING_WIDTH'(i));
            if (flush) begin
                pending_d[i] = '0;
            end else if (inc_hit && !dec_hit) begin
                pending_d[i] = pending_q[i] + PENDING_ONE;
            end else if (dec_hit && !inc_hit) begin
                if (pending_q[i] != '0) begin
                    pending_d[i] = pending_q[i] - PENDING_ONE;
                end else begin
                    underflow_error_d = 1'b1;
                end
            end
        end
        pending_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                pending_q[i] <= '0;
            end
            underflow_error_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                pending_q[i] <= pending_d[i];
            end
            underflow_error_q <= underflow_error_d;
        end
    end

    always_comb begin
        any_pending = 1'b0;
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            any_pending = any_pending | (pending_q[i] != '0);
        end
    end

    assign query_1_contended = (pending_q[query_1] != '0);
    assign query_2_contended = (pending_q[query_2] != '0);
    assign underflow_error   = underflow_error_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: expected post-edge outputs are queued
// when a step is driven and popped/compared one cycle later.
module tb_register_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] query_1;
    logic       query_1_contended;
    logic [4:0] query_2;
    logic       query_2_contended;
    logic       issue_valid;
    logic [4:0] issue_register;
    logic       issue_register_valid;
    logic       issue_ready;
    logic       writeback_valid;
    logic [4:0] writeback_register;
    logic       flush;
    logic       any_pending;
    logic       underflow_error;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string tag;
        logic  q1c;
        logic  q2c;
        logic  ap;
        logic  ir;
        logic  ue;
    } exp_t;

    exp_t exp_q[$];

    register_scoreboard dut (
        .clk                 (clk),
        .rst                 (rst),
        .query_1             (query_1),
        .query_1_contended   (query_1_contended),
        .query_2             (query_2),
        .query_2_contended   (query_2_contended),
        .issue_valid         (issue_valid),
        .issue_register      (issue_register),
        .issue_register_valid(issue_register_valid),
        .issue_ready         (issue_ready),
        .writeback_valid     (writeback_valid),
        .writeback_register  (writeback_register),
        .flush               (flush),
        .any_pending         (any_pending),
        .underflow_error     (underflow_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic q1c, input logic q2c,
                        input logic ap, input logic ir, input logic ue);
        exp_t e;
        e.tag = tag; e.q1c = q1c; e.q2c = q2c; e.ap = ap; e.ir = ir; e.ue = ue;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, ".q1c"}, query_1_contended, e.q1c);
            chk({e.tag, ".q2c"}, query_2_contended, e.q2c);
            chk({e.tag, ".any"}, any_pending,       e.ap);
            chk({e.tag, ".rdy"}, issue_ready,       e.ir);
            chk({e.tag, ".ufl"}, underflow_error,   e.ue);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] ireg, input logic irv,
                         input logic wv, input logic [4:0] wreg, input logic fl);
        issue_valid          = iv;
        issue_register       = ireg;
        issue_register_valid = irv;
        writeback_valid      = wv;
        writeback_register   = wreg;
        flush                = fl;
        #1;
    endtask

    // Clock one edge, drop the one-shot strobes, then compare against the queue head.
    task automatic tick();
        @(posedge clk);
        #1;
        issue_valid     = 1'b0;
        writeback_valid = 1'b0;
        flush           = 1'b0;
        #1;
        pop_check();
    endtask

    initial begin
        rst = 1'b1;
        query_1 = '0; query_2 = '0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        push("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pop_check();

        // Single issue / writeback of r5
        query_1 = 5'd5;
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("r5_no_bypass", query_1_contended, 1'b0);
        push("r5_issued", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        push("r5_hold", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
        chk("r5_wb_no_bypass", query_1_contended, 1'b1);
        push("r5_cleared", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // Saturate r7
        query_2 = 5'd7;
        drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
        push("r7_p1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
        push("r7_p2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
        push("r7_p3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("r7_sat_ready", issue_ready, 1'b0);
        push("r7_ignored", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
        chk("r7_no_wb_credit", issue_ready, 1'b0);
        push("r7_wb1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
        push("r7_wb2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
        push("r7_wb3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // Same-cycle issue and writeback of r9, then r0 issue
        query_1 = 5'd9;
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
        push("r9_p1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0);
        push("r9_both", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0);
        push("r9_clear", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        query_1 = 5'd0; query_2 = 5'd0;
        drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        push("r0_issue", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // Both targeting r13 at zero pending: no error
        query_1 = 5'd13;
        drive(1'b1, 5'd13, 1'b1, 1'b1, 5'd13, 1'b0);
        push("r13_both_zero", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // Flush drops everything including a same-cycle issue
        query_1 = 5'd3; query_2 = 5'd4;
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
        push("r3_issue", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0);
        push("r4_issue", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 1'b1);
        push("flush", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        query_1 = 5'd6;
        #1;
        chk("r6_dropped", query_1_contended, 1'b0);

        // Underflow is sticky through flush, cleared by rst
        query_1 = 5'd12;
        drive(1'b0, 5'd12, 1'b1, 1'b1, 5'd12, 1'b0);
        push("r12_underflow", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 1'b1);
        push("ufl_thru_flush", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0);
        push("r12_issue", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        rst = 1'b1;
        drive(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0);
        push("rst_override", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        #1;

        chk("scoreboard_drained", (exp_q.size() == 0), 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
